// File: rtl/pixel_frame_streamer_pkg.sv
// Shared sizing, state encoding and helpers for the pixel frame streamer.
// Also provides the TRUE/FALSE macros used across the streamer sources.
`ifndef PIXEL_FRAME_STREAMER_PKG_SV
`define PIXEL_FRAME_STREAMER_PKG_SV

`define TRUE  1'b1
`define FALSE 1'b0

package pixel_frame_streamer_pkg;

    localparam int INPUT_LAYER_NODES = 10;
    localparam int WORD_WIDTH        = 8;
    localparam int WORDS             = (INPUT_LAYER_NODES + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int ADDR_WIDTH        = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int IDX_WIDTH         = (INPUT_LAYER_NODES > 1) ? $clog2(INPUT_LAYER_NODES) : 1;
    localparam int FRAME_BITS        = WORDS * WORD_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef logic [IDX_WIDTH-1:0]  idx_t;
    typedef logic [IDX_WIDTH:0]    ones_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam idx_t LAST_IDX = idx_t'(INPUT_LAYER_NODES - 1);

    // Index of the pixel to register next; wraps to 0 so the read never leaves the frame.
    function automatic idx_t next_idx(idx_t i);
        return (i == LAST_IDX) ? '0 : i + idx_t'(1);
    endfunction

endpackage

`endif

// File: rtl/pixel_frame_streamer_if.sv
// Load and pixel-stream signal bundle between host, streamer and input layer controller.
// frameOnes exists only when PIXEL_STREAMER_POPCOUNT_EN is defined.
interface pixel_frame_streamer_if;
    import pixel_frame_streamer_pkg::*;

    logic  loadEnable;
    addr_t loadAddress;
    word_t loadData;
    logic  frameCommit;
    logic  readyForInputs;
    logic  inputsInbound;
    logic  pixelValue;
    logic  frameDone;
    logic  commitError;
    logic  bufferFull;
`ifdef PIXEL_STREAMER_POPCOUNT_EN
    ones_t frameOnes;
`endif

    modport master (
`ifdef PIXEL_STREAMER_POPCOUNT_EN
        input  frameOnes,
`endif
        output loadEnable, loadAddress, loadData, frameCommit, readyForInputs,
        input  inputsInbound, pixelValue, frameDone, commitError, bufferFull
    );

    modport slave (
`ifdef PIXEL_STREAMER_POPCOUNT_EN
        output frameOnes,
`endif
        input  loadEnable, loadAddress, loadData, frameCommit, readyForInputs,
        output inputsInbound, pixelValue, frameDone, commitError, bufferFull
    );

endinterface

// File: rtl/pixel_frame_bank.sv
// One frame of pixel storage: word-wide write port, single-bit read by pixel index.
module pixel_frame_bank
    import pixel_frame_streamer_pkg::*;
(
    input  logic  clk,
    input  logic  we_i,
    input  addr_t waddr_i,
    input  word_t wdata_i,
    input  idx_t  ridx_i,
    output logic  rbit_o
);

    localparam logic [ADDR_WIDTH:0] WORDS_L = (ADDR_WIDTH + 1)'(WORDS);

    logic [WORDS-1:0][WORD_WIDTH-1:0] mem_q;
    logic [FRAME_BITS-1:0]            bits;

    // Contents are not reset; a bank is only read after a full commit.
    always_ff @(posedge clk) begin
        if (we_i && ({1'b0, waddr_i} < WORDS_L)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign bits   = mem_q;
    assign rbit_o = bits[ridx_i];

endmodule

// File: rtl/pixel_frame_streamer.sv
// Double-buffered frame loader that streams one pixel per clock to the input layer.
// Define PIXEL_STREAMER_POPCOUNT_EN to add the frameOnes per-frame ones count.
module pixel_frame_streamer
    import pixel_frame_streamer_pkg::*;
(
    input logic                   clk,
    input logic                   reset,
    pixel_frame_streamer_if.slave bus
);

    state_t     state_q;
    idx_t       cnt_q;
    idx_t       rd_idx;
    logic       wb_q, wb_d;
    logic       rb_q;
    logic [1:0] full_q, full_d;
    logic       cerr_d;
    logic       frame_end;
    logic [1:0] bank_we;
    logic [1:0] bank_bit;
    logic       rd_bit;
`ifdef PIXEL_STREAMER_POPCOUNT_EN
    ones_t      acc_q;
`endif

    assign bank_we[0] = bus.loadEnable && !wb_q && !full_q[0];
    assign bank_we[1] = bus.loadEnable &&  wb_q && !full_q[1];

    pixel_frame_bank u_bank0 (
        .clk     (clk),
        .we_i    (bank_we[0]),
        .waddr_i (bus.loadAddress),
        .wdata_i (bus.loadData),
        .ridx_i  (rd_idx),
        .rbit_o  (bank_bit[0])
    );

    pixel_frame_bank u_bank1 (
        .clk     (clk),
        .we_i    (bank_we[1]),
        .waddr_i (bus.loadAddress),
        .wdata_i (bus.loadData),
        .ridx_i  (rd_idx),
        .rbit_o  (bank_bit[1])
    );

    // Read one pixel ahead so pixelValue is registered alongside inputsInbound.
    assign rd_idx    = (state_q == STREAM) ? next_idx(cnt_q) : '0;
    assign rd_bit    = rb_q ? bank_bit[1] : bank_bit[0];
    assign frame_end = (state_q == STREAM) && (cnt_q == LAST_IDX);

    assign bus.bufferFull = &full_q;

    always_comb begin
        full_d = full_q;
        wb_d   = wb_q;
        cerr_d = `FALSE;
        if (bus.frameCommit) begin
            if (full_q[wb_q]) begin
                cerr_d = `TRUE;
            end else begin
                full_d[wb_q] = `TRUE;
                wb_d         = ~wb_q;
            end
        end
        // A frame end releases the read bank even when a commit lands in the same cycle.
        if (frame_end) begin
            full_d[rb_q] = `FALSE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            wb_q              <= 1'b0;
            rb_q              <= 1'b0;
            full_q            <= '0;
            bus.inputsInbound <= `FALSE;
            bus.pixelValue    <= `FALSE;
            bus.frameDone     <= `FALSE;
            bus.commitError   <= `FALSE;
`ifdef PIXEL_STREAMER_POPCOUNT_EN
            acc_q             <= '0;
            bus.frameOnes     <= '0;
`endif
        end else begin
            full_q          <= full_d;
            wb_q            <= wb_d;
            bus.commitError <= cerr_d;
            bus.frameDone   <= `FALSE;
            case (state_q)
                IDLE: begin
                    if (full_q[rb_q] && bus.readyForInputs) begin
                        state_q           <= STREAM;
                        cnt_q             <= '0;
                        bus.inputsInbound <= `TRUE;
                        bus.pixelValue    <= rd_bit;
`ifdef PIXEL_STREAMER_POPCOUNT_EN
                        acc_q             <= ones_t'(rd_bit);
`endif
                    end
                end
                STREAM: begin
                    if (frame_end) begin
                        state_q           <= DONE;
                        bus.inputsInbound <= `FALSE;
                        bus.pixelValue    <= `FALSE;
                        bus.frameDone     <= `TRUE;
                        rb_q              <= ~rb_q;
`ifdef PIXEL_STREAMER_POPCOUNT_EN
                        bus.frameOnes     <= acc_q;
`endif
                    end else begin
                        cnt_q          <= cnt_q + idx_t'(1);
                        bus.pixelValue <= rd_bit;
`ifdef PIXEL_STREAMER_POPCOUNT_EN
                        acc_q          <= acc_q + ones_t'(rd_bit);
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Directed bench for pixel_frame_streamer; frameOnes checks follow PIXEL_STREAMER_POPCOUNT_EN.
module tb_pixel_frame_streamer;
    import pixel_frame_streamer_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_asrt = 0;
    int   n_fail = 0;

    logic [9:0] px;
    int         ncyc;
    int         wcyc;
    logic       dn1;
    logic       gap_low;
    logic       seen;

    pixel_frame_streamer_if bus();

    pixel_frame_streamer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input logic [ADDR_WIDTH-1:0] a, input logic [7:0] d);
        bus.loadEnable  = 1'b1;
        bus.loadAddress = a;
        bus.loadData    = d;
        tick();
        bus.loadEnable  = 1'b0;
    endtask

    task automatic commit();
        bus.frameCommit = 1'b1;
        tick();
        bus.frameCommit = 1'b0;
    endtask

    // Waits for a frame, captures it, then checks the done pulse and the second gap cycle.
    task automatic stream(input int drop_at, output logic [9:0] p, output int nc,
                          output int wc, output logic d1, output logic gl);
        p  = '0;
        wc = 0;
        while (bus.inputsInbound !== 1'b1 && wc < 100) begin
            tick();
            wc++;
        end
        nc = 0;
        while (bus.inputsInbound === 1'b1 && nc < 20) begin
            if (nc < 10) p[nc] = bus.pixelValue;
            if (nc == drop_at) bus.readyForInputs = 1'b0;
            nc++;
            tick();
        end
        d1 = bus.frameDone;
        tick();
        gl = !bus.inputsInbound && !bus.frameDone;
        tick();
    endtask

    initial begin
        reset              = 1'b1;
        bus.loadEnable     = 1'b0;
        bus.loadAddress    = '0;
        bus.loadData       = '0;
        bus.frameCommit    = 1'b0;
        bus.readyForInputs = 1'b0;
        #12;
        chk("rst_inbound", 32'(bus.inputsInbound), 0);
        chk("rst_pixel",   32'(bus.pixelValue), 0);
        chk("rst_done",    32'(bus.frameDone), 0);
        chk("rst_cerr",    32'(bus.commitError), 0);
        chk("rst_full",    32'(bus.bufferFull), 0);
`ifdef PIXEL_STREAMER_POPCOUNT_EN
        chk("rst_ones",    32'(bus.frameOnes), 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Basic frame: pixels 1 and 2 set
        bus.readyForInputs = 1'b1;
        load(0, 8'b0000_0110);
        load(1, 8'b0000_0000);
        chk("basic_full_before", 32'(bus.bufferFull), 0);
        commit();
        stream(-1, px, ncyc, wcyc, dn1, gap_low);
        chk("basic_wait",   32'(wcyc), 1);
        chk("basic_pixels", 32'(px), 32'h006);
        chk("basic_len",    32'(ncyc), 10);
        chk("basic_done",   32'(dn1), 1);
        chk("basic_gap",    32'(gap_low), 1);
`ifdef PIXEL_STREAMER_POPCOUNT_EN
        chk("basic_ones",   32'(bus.frameOnes), 2);
`endif
        chk("basic_full_after", 32'(bus.bufferFull), 0);

        // Padding bits in the last word are dropped
        load(0, 8'h00);
        load(1, 8'hFF);
        commit();
        stream(-1, px, ncyc, wcyc, dn1, gap_low);
        chk("pad_wait",   32'(wcyc), 1);
        chk("pad_pixels", 32'(px), 32'h300);
        chk("pad_len",    32'(ncyc), 10);
        chk("pad_done",   32'(dn1), 1);
`ifdef PIXEL_STREAMER_POPCOUNT_EN
        chk("pad_ones",   32'(bus.frameOnes), 2);
`endif

        // Two frames queued, third commit rejected, write into a full bank dropped
        bus.readyForInputs = 1'b0;
        load(0, 8'hA5);
        load(1, 8'h01);
        commit();
        load(0, 8'h3C);
        load(1, 8'h03);
        commit();
        chk("b2b_full",      32'(bus.bufferFull), 1);
        chk("b2b_cerr_idle", 32'(bus.commitError), 0);
        commit();
        chk("b2b_cerr_pulse", 32'(bus.commitError), 1);
        tick();
        chk("b2b_cerr_clear", 32'(bus.commitError), 0);
        chk("b2b_full_kept",  32'(bus.bufferFull), 1);
        load(0, 8'hFF);
        bus.readyForInputs = 1'b1;
        stream(-1, px, ncyc, wcyc, dn1, gap_low);
        chk("a_wait",   32'(wcyc), 1);
        chk("a_pixels", 32'(px), 32'h1A5);
        chk("a_len",    32'(ncyc), 10);
        chk("a_done",   32'(dn1), 1);
        chk("a_gap",    32'(gap_low), 1);
`ifdef PIXEL_STREAMER_POPCOUNT_EN
        chk("a_ones",   32'(bus.frameOnes), 5);
`endif
        stream(-1, px, ncyc, wcyc, dn1, gap_low);
        chk("b_wait",   32'(wcyc), 0);
        chk("b_pixels", 32'(px), 32'h33C);
        chk("b_len",    32'(ncyc), 10);
        chk("b_done",   32'(dn1), 1);
`ifdef PIXEL_STREAMER_POPCOUNT_EN
        chk("b_ones",   32'(bus.frameOnes), 6);
`endif
        chk("b2b_empty", 32'(bus.bufferFull), 0);

        // readyForInputs gating and mid-frame drop
        bus.readyForInputs = 1'b0;
        load(0, 8'h5A);
        load(1, 8'h02);
        commit();
        repeat (5) tick();
        chk("rdy_held_off", 32'(bus.inputsInbound), 0);
        bus.readyForInputs = 1'b1;
        stream(3, px, ncyc, wcyc, dn1, gap_low);
        chk("rdy_wait",   32'(wcyc), 1);
        chk("rdy_pixels", 32'(px), 32'h25A);
        chk("rdy_len",    32'(ncyc), 10);
        chk("rdy_done",   32'(dn1), 1);
`ifdef PIXEL_STREAMER_POPCOUNT_EN
        chk("rdy_ones",   32'(bus.frameOnes), 5);
`endif

        // Reset while pixel 4 is on the bus
        bus.readyForInputs = 1'b1;
        load(0, 8'hFF);
        load(1, 8'h03);
        commit();
        wcyc = 0;
        while (bus.inputsInbound !== 1'b1 && wcyc < 100) begin
            tick();
            wcyc++;
        end
        chk("rstm_started", 32'(bus.inputsInbound), 1);
        repeat (4) tick();
        chk("rstm_pix4", 32'(bus.inputsInbound), 1);
        reset = 1'b1;
        #1;
        chk("rstm_inbound", 32'(bus.inputsInbound), 0);
        chk("rstm_full",    32'(bus.bufferFull), 0);
        chk("rstm_done",    32'(bus.frameDone), 0);
`ifdef PIXEL_STREAMER_POPCOUNT_EN
        chk("rstm_ones",    32'(bus.frameOnes), 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (15) begin
            tick();
            seen = seen | bus.frameDone | bus.inputsInbound;
        end
        chk("rstm_quiet", 32'(seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
